llr_join_arbiter: RTL and testbench

LLR_JOIN_ARBITER -- requirements
Module: llr_join_arbiter

---
 rtl/pfifo_pkg.sv | 15 +
 rtl/llr_quota_cnt.sv | 46 ++++
 rtl/llr_join_arbiter.sv | 145 ++++++++++++++
 tb/tb_llr_join_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pfifo_pkg.sv
// rtl/pfifo_pkg.sv - shared LLR packing FIFO constants and join FSM state type
package pfifo_pkg;
  localparam int LLR_W          = 6;
  localparam int BEAT_LLR_MAX   = 16;
  localparam int BEAT_W         = LLR_W * BEAT_LLR_MAX;
  localparam int FIFO_DEPTH_LLR = 48;
  localparam int QUOTA_W        = 16;
  localparam int AMT_W          = $clog2(BEAT_LLR_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } join_state_t;
endpackage

// File: rtl/llr_quota_cnt.sv
// rtl/llr_quota_cnt.sv - per-requester remaining-LLR counter with overrun clipping
module llr_quota_cnt
  import pfifo_pkg::*;
(
  input  logic               i_core_clk,
  input  logic               i_rx_rstn,
  input  logic               i_load,
  input  logic [QUOTA_W-1:0] i_load_val,
  input  logic               i_dec,
  input  logic [AMT_W-1:0]   i_amount,
  output logic               o_zero,
  output logic               o_zero_next,
  output logic               o_overrun,
  output logic [AMT_W-1:0]   o_amount
);
  logic [QUOTA_W-1:0] r_rem;
  logic [QUOTA_W-1:0] w_need;
  logic [QUOTA_W-1:0] w_sub;
  logic [QUOTA_W-1:0] w_next;
  logic               w_overrun;

  assign w_need    = QUOTA_W'(i_amount) + QUOTA_W'(1);
  assign w_overrun = w_need > r_rem;
  assign w_sub     = w_overrun ? '0 : r_rem - w_need;

  always_comb begin
    w_next = r_rem;
    if (i_load)
      w_next = i_load_val;
    else if (i_dec)
      w_next = w_sub;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn)
      r_rem <= '0;
    else
      r_rem <= w_next;
  end

  assign o_zero      = (r_rem == '0);
  assign o_zero_next = (w_next == '0);
  assign o_overrun   = w_overrun;
  // An overrunning beat is clipped to whatever quota is left; never granted at zero.
  assign o_amount    = w_overrun ? AMT_W'(r_rem - QUOTA_W'(1)) : i_amount;
endmodule

// File: rtl/llr_join_arbiter.sv
// rtl/llr_join_arbiter.sv - round-robin join of two LLR requesters into the packing FIFO
module llr_join_arbiter
  import pfifo_pkg::*;
(
  input  logic               i_core_clk,
  input  logic               i_rx_rstn,
  input  logic               i_start,
  input  logic [QUOTA_W-1:0] i_quota0,
  input  logic [QUOTA_W-1:0] i_quota1,
  input  logic               rq0_valid,
  input  logic [AMT_W-1:0]   rq0_amount,
  input  logic [BEAT_W-1:0]  rq0_data,
  output logic               rq0_ready,
  input  logic               rq1_valid,
  input  logic [AMT_W-1:0]   rq1_amount,
  input  logic [BEAT_W-1:0]  rq1_data,
  output logic               rq1_ready,
  output logic               o_join_enable,
  output logic [AMT_W-1:0]   o_join_amount,
  output logic [BEAT_W-1:0]  o_join_data,
  input  logic               i_join_permit,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);
  join_state_t      r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_last;
  logic             r_lock;
  logic             r_lock_id;

  logic             w_load;
  logic             w_zero0, w_zero1;
  logic             w_zero_next0, w_zero_next1;
  logic             w_ovr0, w_ovr1;
  logic [AMT_W-1:0] w_amt0, w_amt1;
  logic             w_elig0, w_elig1;
  logic             w_gnt_any;
  logic             w_gnt_id;
  logic             w_xfer;

  assign w_load  = (r_state == IDLE) && i_start;
  assign w_elig0 = (r_state == RUN) && rq0_valid && !w_zero0;
  assign w_elig1 = (r_state == RUN) && rq1_valid && !w_zero1;

  llr_quota_cnt u_cnt0 (
    .i_core_clk  (i_core_clk),
    .i_rx_rstn   (i_rx_rstn),
    .i_load      (w_load),
    .i_load_val  (i_quota0),
    .i_dec       (rq0_ready),
    .i_amount    (rq0_amount),
    .o_zero      (w_zero0),
    .o_zero_next (w_zero_next0),
    .o_overrun   (w_ovr0),
    .o_amount    (w_amt0)
  );

  llr_quota_cnt u_cnt1 (
    .i_core_clk  (i_core_clk),
    .i_rx_rstn   (i_rx_rstn),
    .i_load      (w_load),
    .i_load_val  (i_quota1),
    .i_dec       (rq1_ready),
    .i_amount    (rq1_amount),
    .o_zero      (w_zero1),
    .o_zero_next (w_zero_next1),
    .o_overrun   (w_ovr1),
    .o_amount    (w_amt1)
  );

  // Permit is deliberately absent here: the FIFO derives it from o_join_amount.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = 1'b0;
    if (r_lock && (r_lock_id ? w_elig1 : w_elig0)) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (w_elig0 && w_elig1) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = ~r_last;
    end else if (w_elig0 || w_elig1) begin
      w_gnt_any = 1'b1;
      w_gnt_id  = w_elig1;
    end
  end

  assign w_xfer        = w_gnt_any && i_join_permit;
  assign rq0_ready     = w_xfer && !w_gnt_id;
  assign rq1_ready     = w_xfer && w_gnt_id;
  assign o_join_enable = w_gnt_any;
  assign o_join_amount = !w_gnt_any ? '0 : (w_gnt_id ? w_amt1 : w_amt0);
  assign o_join_data   = !w_gnt_any ? '0 : (w_gnt_id ? rq1_data : rq0_data);
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= 1'b1;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      // A stalled grant stays locked; a dropped valid simply re-arbitrates.
      r_lock <= w_gnt_any && !i_join_permit;
      if (w_gnt_any)
        r_lock_id <= w_gnt_id;
      if (w_xfer)
        r_last <= w_gnt_id;
      if (w_xfer && (w_gnt_id ? w_ovr1 : w_ovr0))
        r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        RUN: begin
          if (w_zero_next0 && w_zero_next1) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_llr_join_arbiter.sv
// tb/tb_llr_join_arbiter.sv - directed scoreboard bench for llr_join_arbiter
module tb_llr_join_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] quota0, quota1;
  logic        v0, v1;
  logic [3:0]  a0, a1;
  logic [95:0] d0, d1;
  logic        r0, r1;
  logic        j_en;
  logic [3:0]  j_amt;
  logic [95:0] j_data;
  logic        permit;
  logic        busy, done, err;

  typedef struct packed {
    logic        id;
    logic [3:0]  amt;
    logic [95:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  llr_join_arbiter dut (
    .i_core_clk    (clk),
    .i_rx_rstn     (rstn),
    .i_start       (start),
    .i_quota0      (quota0),
    .i_quota1      (quota1),
    .rq0_valid     (v0),
    .rq0_amount    (a0),
    .rq0_data      (d0),
    .rq0_ready     (r0),
    .rq1_valid     (v1),
    .rq1_amount    (a1),
    .rq1_data      (d1),
    .rq1_ready     (r1),
    .o_join_enable (j_en),
    .o_join_amount (j_amt),
    .o_join_data   (j_data),
    .i_join_permit (permit),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Pops the scoreboard on every transfer seen at the negative edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (j_en && permit) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", 96'd1, 96'd0);
      end else begin
        e = sb.pop_front();
        chk("xfer_amount", 96'(j_amt), 96'(e.amt));
        chk("xfer_data", j_data, e.data);
        chk("xfer_ready", 96'({r1, r0}), e.id ? 96'd2 : 96'd1);
      end
    end else begin
      chk("ready_idle", 96'({r1, r0}), 96'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] q0, input logic [15:0] q1);
    quota0 = q0;
    quota1 = q1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    logic [95:0] da, db;
    rstn = 1'b0; start = 1'b0; quota0 = '0; quota1 = '0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; permit = 1'b1;
    #2;
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_err", 96'(err), 96'd0);
    chk("rst_en", 96'(j_en), 96'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Round robin, quotas 8/8, both valid: order 0,1,0,1.
    start_job(16'd8, 16'd8);
    v0 = 1'b1; v1 = 1'b1; a0 = 4'd3; a1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      d0 = rnd96(); d1 = rnd96();
      sb.push_back('{id: i[0], amt: 4'd3, data: i[0] ? d1 : d0});
      tick();
    end
    chk("rr_done", 96'(done), 96'd1);
    chk("rr_err", 96'(err), 96'd0);
    v0 = 1'b0; v1 = 1'b0;
    tick();
    chk("rr_idle_busy", 96'(busy), 96'd0);

    // Two full beats back to back; a start during RUN must be ignored.
    start_job(16'd32, 16'd0);
    start = 1'b1; quota0 = '0; quota1 = '0;
    v0 = 1'b1; a0 = 4'd15; d0 = rnd96();
    sb.push_back('{id: 1'b0, amt: 4'd15, data: d0});
    tick();
    start = 1'b0;
    chk("full_mid_done", 96'(done), 96'd0);
    d0 = rnd96();
    sb.push_back('{id: 1'b0, amt: 4'd15, data: d0});
    tick();
    chk("full_done", 96'(done), 96'd1);
    chk("full_busy", 96'(busy), 96'd1);
    v0 = 1'b0;
    tick();
    chk("full_done_clr", 96'(done), 96'd0);
    chk("full_busy_clr", 96'(busy), 96'd0);

    // Stalled grant on 0 holds against a newly valid rq1.
    start_job(16'd4, 16'd4);
    da = rnd96(); db = rnd96();
    v0 = 1'b1; a0 = 4'd3; d0 = da; permit = 1'b0;
    #1;
    chk("lock_en", 96'(j_en), 96'd1);
    tick();
    v1 = 1'b1; a1 = 4'd3; d1 = db;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lock_data", j_data, da);
      chk("lock_r1", 96'(r1), 96'd0);
      tick();
    end
    permit = 1'b1;
    sb.push_back('{id: 1'b0, amt: 4'd3, data: da});
    sb.push_back('{id: 1'b1, amt: 4'd3, data: db});
    tick();
    tick();
    chk("lock_done", 96'(done), 96'd1);
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // Overrun: quota 5 against a 16-LLR beat.
    start_job(16'd5, 16'd0);
    v0 = 1'b1; a0 = 4'd15; d0 = rnd96();
    #1;
    chk("ovr_amount", 96'(j_amt), 96'd4);
    sb.push_back('{id: 1'b0, amt: 4'd4, data: d0});
    tick();
    chk("ovr_done", 96'(done), 96'd1);
    chk("ovr_err", 96'(err), 96'd1);
    v0 = 1'b0;
    tick();
    chk("ovr_err_sticky", 96'(err), 96'd1);

    // Zero quotas: busy two cycles, done on the second, no grant.
    v0 = 1'b1; v1 = 1'b1;
    start_job(16'd0, 16'd0);
    chk("zq_busy1", 96'(busy), 96'd1);
    chk("zq_done1", 96'(done), 96'd0);
    chk("zq_err_clr", 96'(err), 96'd0);
    chk("zq_en", 96'(j_en), 96'd0);
    tick();
    chk("zq_busy2", 96'(busy), 96'd1);
    chk("zq_done2", 96'(done), 96'd1);
    tick();
    chk("zq_busy3", 96'(busy), 96'd0);
    v0 = 1'b0; v1 = 1'b0;

    // Reset mid-RUN abandons the job.
    start_job(16'd16, 16'd16);
    v0 = 1'b1; a0 = 4'd3; d0 = rnd96();
    sb.push_back('{id: 1'b0, amt: 4'd3, data: d0});
    tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_en", 96'(j_en), 96'd0);
    chk("mid_rst_busy", 96'(busy), 96'd0);
    chk("mid_rst_rdy", 96'({r1, r0}), 96'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_nodone", 96'(done), 96'd0);
    end
    rstn = 1'b1; v0 = 1'b0;
    tick();
    start_job(16'd4, 16'd0);
    v0 = 1'b1; a0 = 4'd3; d0 = rnd96();
    sb.push_back('{id: 1'b0, amt: 4'd3, data: d0});
    tick();
    chk("clean_done", 96'(done), 96'd1);
    chk("clean_err", 96'(err), 96'd0);
    v0 = 1'b0;
    tick();
    chk("sb_empty", 96'(sb.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
